// File: rtl/shift_operand_gen_pkg.sv
// Shared constants for the barrel-shifter operand producer: shift types,
// FSM state encoding and data-processing instruction field positions.
package shift_operand_gen_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ_RM = 2'd1,
    ST_READ_RS = 2'd2,
    ST_ISSUE   = 2'd3
  } state_e;

  localparam int I_BIT      = 25;
  localparam int REGSH_BIT  = 4;
  localparam int RM_LSB     = 0;
  localparam int RM_MSB     = 3;
  localparam int RS_LSB     = 8;
  localparam int RS_MSB     = 11;
  localparam int ROT_LSB    = 8;
  localparam int ROT_MSB    = 11;
  localparam int IMM_LSB    = 0;
  localparam int IMM_MSB    = 7;
  localparam int SHAMT_LSB  = 7;
  localparam int SHAMT_MSB  = 11;
  localparam int TYPE_LSB   = 5;
  localparam int TYPE_MSB   = 6;

  // Immediate operands are always a rotate-right by an even amount.
  localparam logic [2:0] OP_IMM_ROT = {SH_ROR, 1'b1};

endpackage

// File: rtl/shift_operand_gen_decode.sv
// Pure field-to-operand mapping of a data-processing instruction word.
module shift_field_decode
  import shift_operand_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 8
) (
  input  logic [31:0]       inst,
  output logic              is_imm,
  output logic              is_regsh,
  output logic [3:0]        rm_addr,
  output logic [3:0]        rs_addr,
  output logic [DATA_W-1:0] imm_data,
  output logic [NUM_W-1:0]  imm_num,
  output logic [2:0]        op
);

  logic unused_inst_bits;

  // Decode mode, register addresses and the immediate-derived operands.
  always_comb begin
    is_imm   = inst[I_BIT];
    is_regsh = ~inst[I_BIT] & inst[REGSH_BIT];
    rm_addr  = inst[RM_MSB:RM_LSB];
    rs_addr  = inst[RS_MSB:RS_LSB];
    imm_data = DATA_W'(inst[IMM_MSB:IMM_LSB]);
    if (inst[I_BIT]) begin
      // rotate field counts in units of two bit positions
      imm_num = NUM_W'({inst[ROT_MSB:ROT_LSB], 1'b0});
      op      = OP_IMM_ROT;
    end else begin
      imm_num = NUM_W'(inst[SHAMT_MSB:SHAMT_LSB]);
      op      = {inst[TYPE_MSB:TYPE_LSB], inst[REGSH_BIT]};
    end
  end

  assign unused_inst_bits = ^{inst[31:26], inst[24:12]};

endmodule

// File: rtl/shift_operand_gen.sv
// Barrel-shifter operand producer: accepts one instruction, reads Rm/Rs
// through a single register-file port and presents the shifter operands
// with a valid/ready handshake.
module shift_operand_gen
  import shift_operand_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic              c_flag,
  input  logic              flush,
  output logic [3:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Shift_Data,
  output logic [NUM_W-1:0]  Shift_Num,
  output logic [2:0]        Shift_op,
  output logic              Carry_Flags
);

  state_e              state_q, state_d;
  logic [31:0]         inst_q, inst_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [2:0]          op_q, op_d;
  logic                carry_q, carry_d;
  logic [3:0]          rf_addr_q, rf_addr_d;

  logic [31:0]         dec_inst;
  logic                dec_is_imm, dec_is_regsh;
  logic [3:0]          dec_rm, dec_rs;
  logic [DATA_W-1:0]   dec_imm_data;
  logic [NUM_W-1:0]    dec_imm_num;
  logic [2:0]          dec_op;

  // In IDLE the incoming word is decoded so the accept edge can load
  // everything known from the instruction alone; afterwards the latched copy.
  assign dec_inst = (state_q == ST_IDLE) ? inst : inst_q;

  shift_field_decode #(.DATA_W(DATA_W), .NUM_W(NUM_W)) u_decode (
    .inst     (dec_inst),
    .is_imm   (dec_is_imm),
    .is_regsh (dec_is_regsh),
    .rm_addr  (dec_rm),
    .rs_addr  (dec_rs),
    .imm_data (dec_imm_data),
    .imm_num  (dec_imm_num),
    .op       (dec_op)
  );

  // Next-state and operand-capture logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    data_d    = data_q;
    num_d     = num_q;
    op_d      = op_q;
    carry_d   = carry_q;
    rf_addr_d = rf_addr_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            inst_d  = inst;
            carry_d = c_flag;
            op_d    = dec_op;
            num_d   = dec_imm_num;
            if (dec_is_imm) begin
              data_d  = dec_imm_data;
              state_d = ST_ISSUE;
            end else begin
              rf_addr_d = dec_rm;
              state_d   = ST_READ_RM;
            end
          end
        end
        ST_READ_RM: begin
          data_d = rf_rdata;
          if (dec_is_regsh) begin
            rf_addr_d = dec_rs;
            state_d   = ST_READ_RS;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_READ_RS: begin
          num_d   = NUM_W'(rf_rdata[7:0]);
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and operand registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= '0;
      data_q    <= '0;
      num_q     <= '0;
      op_q      <= '0;
      carry_q   <= 1'b0;
      rf_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      data_q    <= data_d;
      num_q     <= num_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      rf_addr_q <= rf_addr_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_ISSUE);
  assign rf_addr     = rf_addr_q;
  assign Shift_Data  = data_q;
  assign Shift_Num   = num_q;
  assign Shift_op    = op_q;
  assign Carry_Flags = carry_q;

endmodule

// File: tb/tb_shift_operand_gen.sv
// Self-checking bench for shift_operand_gen: directed cases plus random
// instructions compared against an arithmetic model of the operand rules.
module tb_shift_operand_gen;

  localparam int DATA_W = 32;
  localparam int NUM_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       inst = '0;
  logic              c_flag = 1'b0;
  logic              flush = 1'b0;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] Shift_Data;
  logic [NUM_W-1:0]  Shift_Num;
  logic [2:0]        Shift_op;
  logic              Carry_Flags;

  logic [31:0] rf [16];
  int compared = 0;
  int mismatched = 0;

  assign rf_rdata = rf[rf_addr];

  always #5 clk = ~clk;

  shift_operand_gen #(.DATA_W(DATA_W), .NUM_W(NUM_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .c_flag      (c_flag),
    .flush       (flush),
    .rf_addr     (rf_addr),
    .rf_rdata    (rf_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Shift_Data  (Shift_Data),
    .Shift_Num   (Shift_Num),
    .Shift_op    (Shift_op),
    .Carry_Flags (Carry_Flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ops(input string tag, input logic [31:0] ed, input logic [31:0] en,
                           input logic [31:0] eo, input logic ec);
    check({tag, ".data"}, Shift_Data, ed);
    check({tag, ".num"}, 32'(Shift_Num), en);
    check({tag, ".op"}, 32'(Shift_op), eo);
    check({tag, ".carry"}, 32'(Carry_Flags), 32'(ec));
  endtask

  // Offer one instruction, follow it to ISSUE, hold it for `stall` cycles,
  // then consume it. Expected values come from the arithmetic model below.
  task automatic run_inst(input string tag, input logic [31:0] ins, input logic c, input int stall);
    logic [31:0] ed, en, eo;
    int          elat, lat;
    logic [3:0]  eaddr[$];
    logic [3:0]  seen[$];
    if (ins[25]) begin
      ed   = ins & 32'hFF;
      en   = ((ins >> 8) & 32'hF) * 2;
      eo   = 7;
      elat = 1;
    end else begin
      ed = rf[ins[3:0]];
      eaddr.push_back(ins[3:0]);
      if (ins[4]) begin
        en   = rf[ins[11:8]] % 256;
        eo   = ((ins >> 5) & 3) * 2 + 1;
        elat = 3;
        eaddr.push_back(ins[11:8]);
      end else begin
        en   = (ins >> 7) & 32'h1F;
        eo   = ((ins >> 5) & 3) * 2;
        elat = 2;
      end
    end
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    inst     = ins;
    c_flag   = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inst     = $urandom;
    c_flag   = ~c;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      seen.push_back(rf_addr);
    end
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".nreads"}, 32'(seen.size()), 32'(eaddr.size()));
    for (int i = 0; i < eaddr.size() && i < seen.size(); i++)
      check({tag, ".rf_addr"}, 32'(seen[i]), 32'(eaddr[i]));
    check_ops(tag, ed, en, eo, c);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(out_valid), 1);
      check({tag, ".stall_in_ready"}, 32'(in_ready), 0);
      check_ops({tag, ".stall"}, ed, en, eo, c);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(out_valid), 0);
    check({tag, ".done_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;

    // reset state
    #12;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.data", Shift_Data, 0);
    check("rst.num", 32'(Shift_Num), 0);
    check("rst.op", 32'(Shift_op), 0);
    check("rst.carry", 32'(Carry_Flags), 0);
    check("rst.rf_addr", 32'(rf_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 1);

    // directed cases
    run_inst("imm", 32'hE3A004FF, 1'b1, 0);
    rf[2] = 32'h80000001;
    run_inst("lsl3", 32'hE1A00182, 1'b0, 0);
    rf[2] = 32'hF0000000;
    rf[3] = 32'h12345621;
    run_inst("asr_reg", 32'hE1A00352, 1'b1, 5);
    run_inst("lsr0", 32'hE1A00022, 1'b0, 1);
    run_inst("imm_rot0", 32'hE3A00042, 1'b0, 0);
    rf[15] = 32'h0000_1008;
    run_inst("r15", 32'hE1A0000F, 1'b1, 0);

    // flush during READ_RS
    rf[2] = 32'hCAFE0002;
    @(negedge clk);
    in_valid = 1'b1;
    inst     = 32'hE1A00352;
    c_flag   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush.rf_addr_rs", 32'(rf_addr), 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.in_ready", 32'(in_ready), 1);
    check("flush.out_valid", 32'(out_valid), 0);
    check("flush.data_kept", Shift_Data, 32'hCAFE0002);
    repeat (3) begin
      @(negedge clk);
      check("flush.no_valid", 32'(out_valid), 0);
    end

    // flush in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    inst     = 32'hE3A004FF;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle.in_ready", 32'(in_ready), 1);
    repeat (2) begin
      @(negedge clk);
      check("flush_idle.no_valid", 32'(out_valid), 0);
    end

    // flush in ISSUE outranks out_ready
    @(negedge clk);
    in_valid = 1'b1;
    inst     = 32'hE3A00011;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_issue.valid", 32'(out_valid), 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_issue.dropped", 32'(out_valid), 0);
    check("flush_issue.data_kept", Shift_Data, 32'h11);

    // asynchronous reset while in ISSUE
    @(negedge clk);
    in_valid = 1'b1;
    inst     = 32'hE3A004FF;
    c_flag   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst.pre_valid", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(out_valid), 0);
    check("arst.data", Shift_Data, 0);
    check("arst.num", 32'(Shift_Num), 0);
    check("arst.op", 32'(Shift_op), 0);
    check("arst.carry", 32'(Carry_Flags), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("arst.no_valid", 32'(out_valid), 0);
    end

    // random instructions
    for (int n = 0; n < 60; n++) begin
      if (n % 8 == 0) for (int i = 0; i < 16; i++) rf[i] = $urandom;
      run_inst("rand", $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_operand_gen.md
Name: shift_operand_gen

Overview:
- Producer side of the barrel-shifter interface. Takes an ARM data-processing instruction and the current C flag.
- Reads Rm and, when needed, Rs through a single register-file read port.
- Presents Shift_Data, Shift_Num, Shift_op and Carry_Flags to the barrel shifter with a valid/ready handshake.
- Sits between the decode stage and the shifter/ALU datapath.

Parameters:
- DATA_W, 32, operand width.
- NUM_W, 8, shift-amount width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept an instruction; equals (state==IDLE).
- inst  input  32  data-processing instruction word.
- c_flag  input  1  CPSR C at offer time.
- flush  input  1  synchronous abort of the instruction in flight.
- rf_addr  output  4  register-file read address.
- rf_rdata  input  DATA_W  read data, combinational, same cycle as rf_addr.
- out_valid  output  1  shifter operands valid.
- out_ready  input  1  shifter/ALU consumes the operands.
- Shift_Data  output  DATA_W  operand to be shifted.
- Shift_Num  output  NUM_W  shift amount.
- Shift_op  output  3  [2:1] type (00 LSL, 01 LSR, 10 ASR, 11 ROR); [0]=1 register/rotate form, [0]=0 immediate-shift form.
- Carry_Flags  output  1  captured C flag.

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; Shift_Data=0; Shift_Num=0; Shift_op=0; Carry_Flags=0; rf_addr=0. in_ready is 1 once rst deasserts.
- Accept: in IDLE with in_valid=1, latch inst and c_flag. Carry_Flags is taken from the latched c_flag and is not resampled later.
- State machine: IDLE, READ_RM, READ_RS, ISSUE.
  - IDLE -> ISSUE when inst[25]=1 (immediate).
  - IDLE -> READ_RM when inst[25]=0.
  - READ_RM: rf_addr=inst[3:0]; capture Shift_Data=rf_rdata. Next state READ_RS if inst[4]=1, else ISSUE.
  - READ_RS: rf_addr=inst[11:8]; capture Shift_Num=rf_rdata[7:0]. Next state ISSUE.
  - ISSUE: out_valid=1. On out_ready=1 -> IDLE, out_valid drops the next cycle.
- Operand rules:
  - Immediate (inst[25]=1): Shift_Data={24'b0,inst[7:0]}; Shift_Num={3'b0,inst[11:8],1'b0}; Shift_op=3'b111. Rotate 0 therefore passes the data through.
  - Immediate shift (inst[25]=0, inst[4]=0): Shift_Num={3'b0,inst[11:7]}; Shift_op={inst[6:5],1'b0}. Amount 0 selects the shifter special cases (LSR#32, ASR#32, RRX).
  - Register shift (inst[25]=0, inst[4]=1): Shift_op={inst[6:5],1'b1}; Shift_Num=Rs[7:0]; Rs[31:8] is ignored.
- Latency from accept to out_valid: 1 cycle (immediate), 2 cycles (immediate shift), 3 cycles (register shift).
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
- rf_addr: the address is held at its last value in IDLE and ISSUE.
- Register 15: r15 is read as supplied by the register file; this block applies no PC adjustment.
- flush=1 in any state: next state IDLE, out_valid=0, operand registers keep their values.
  - flush outranks out_ready.
  - flush in IDLE blocks acceptance that cycle.
- rst mid-operation: the instruction is discarded immediately and no out_valid is produced.
- Throughput: in_ready is 0 outside IDLE, so at most one instruction is in flight.

Decomposition:
- Shared package: shift-type constants SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11; state encoding; instruction field positions (I_BIT=25, REGSH_BIT=4, RM/RS/ROT/IMM field ranges).
- The field-to-operand mapping is one natural combinational sub-module, shift_field_decode: inst in; mode, rm/rs addresses, immediate data, immediate amount and op out. The FSM and registers stay in the top.

Test Plan:
- Immediate: inst=0xE3A004FF (rot=4, imm=0xFF), c_flag=1 -> one cycle after accept: out_valid=1, Shift_Data=0x000000FF, Shift_Num=8, Shift_op=3'b111, Carry_Flags=1; no read issued.
- Immediate LSL: inst=0xE1A00182 (Rm=r2, LSL #3), rf r2=0x80000001 -> READ_RM shows rf_addr=2; after 2 cycles Shift_Data=0x80000001, Shift_Num=3, Shift_op=3'b000.
- Register ASR: inst=0xE1A00352 (Rm=r2, ASR Rs=r3), r2=0xF0000000, r3=0x12345621 -> rf_addr=2 then rf_addr=3; after 3 cycles Shift_Num=0x21, Shift_op=3'b101, Shift_Data=0xF0000000.
- Backpressure: out_ready held 0 for 5 cycles in ISSUE -> outputs bit-stable and in_ready=0; out_ready=1 -> IDLE next cycle, out_valid=0.
- Flush/reset: flush pulse during READ_RS -> no out_valid, in_ready=1 next cycle; rst asserted asynchronously in ISSUE -> out_valid=0 and operand outputs=0 before the next clock edge.
- Special amount: inst=0xE1A00022 (LSR #0, Rm=r2) -> Shift_Num=0, Shift_op=3'b010 (shifter's LSR #32 case).
